// File: rtl/handshake_burst_source.sv
// handshake_burst_source: valid/ready stream initiator emitting incrementing-data bursts with optional inter-beat gaps
module handshake_burst_source #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 8,
   parameter int GAP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [WIDTH-1:0] start_data,
   input  logic [GAP_W-1:0] gap,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
   state_t           r_state, w_state_n;
   logic [LEN_W-1:0] r_rem, w_rem_n;
   logic [GAP_W-1:0] r_gap_q, w_gap_q_n, r_gap_cnt, w_gap_cnt_n;
   logic [WIDTH-1:0] w_data_n;
   logic             w_hs;
   assign w_hs = m_valid && m_ready;
   // next-state and counter updates; outputs are derived from the next state so they come straight off flops
   always_comb begin
      w_state_n   = r_state;
      w_rem_n     = r_rem;
      w_gap_q_n   = r_gap_q;
      w_gap_cnt_n = r_gap_cnt;
      w_data_n    = m_data;
      case (r_state)
         IDLE: if (start) begin
            if (len != '0) begin
               w_state_n = SEND;
               w_rem_n   = len;
               w_gap_q_n = gap;
               w_data_n  = start_data;
            end else begin
               w_state_n = DONE;
            end
         end
         SEND: if (w_hs) begin
            w_rem_n = r_rem - 1'b1;
            if (r_rem == LEN_W'(1)) begin
               w_state_n = DONE;
            end else begin
               w_data_n = m_data + 1'b1;
               if (r_gap_q != '0) begin
                  w_state_n   = GAP;
                  w_gap_cnt_n = r_gap_q;
               end
            end
         end
         GAP: begin
            w_state_n   = (r_gap_cnt == GAP_W'(1)) ? SEND : GAP;
            w_gap_cnt_n = r_gap_cnt - 1'b1;
         end
         DONE:    w_state_n = IDLE;
         default: w_state_n = IDLE;
      endcase
   end
   // state, counters and registered stream/status outputs; reset abandons any burst in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_rem     <= '0;
         r_gap_q   <= '0;
         r_gap_cnt <= '0;
         m_data    <= '0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_rem     <= w_rem_n;
         r_gap_q   <= w_gap_q_n;
         r_gap_cnt <= w_gap_cnt_n;
         m_data    <= w_data_n;
         m_valid   <= (w_state_n == SEND);
         m_last    <= (w_state_n == SEND) && (w_rem_n == LEN_W'(1));
         busy      <= (w_state_n != IDLE);
         done      <= (w_state_n == DONE);
      end
   end
endmodule

// File: tb/tb_handshake_burst_source.sv
// tb_handshake_burst_source: directed bursts with a beat scoreboard and per-cycle control pattern checks
module tb_handshake_burst_source;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] len = '0;
   logic [7:0] start_data = '0;
   logic [3:0] gap = '0;
   logic       m_valid, m_ready = 1'b0, m_last, busy, done;
   logic [7:0] m_data;
   int         checks = 0, failures = 0;
   int         hs_cnt = 0, done_cnt = 0, hs_base = 0, done_base = 0;
   logic [8:0] sb[$];
   logic [15:0] cv, cl, cd, cb;
   logic [7:0] cdat[16];

   handshake_burst_source #(.WIDTH(8), .LEN_W(8), .GAP_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .start_data(start_data),
      .gap(gap), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_last(m_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // scoreboard monitor: every accepted beat must match the next expected {last,data}
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         hs_cnt++;
         if (sb.size() == 0) chk("unexpected_beat", {23'd0, m_last, m_data}, 32'h1ff);
         else chk("beat", {23'd0, m_last, m_data}, {23'd0, sb.pop_front()});
      end
      if (!rst && done) done_cnt++;
   end

   // issue a start at the next edge, then drive per-cycle ready/start/reset and capture outputs
   task run(input int ln, input int sd, input int gp, input int np, input int n,
            input logic [15:0] rdy, input logic [15:0] st, input logic [15:0] rv);
      hs_base = hs_cnt;
      done_base = done_cnt;
      for (int i = 0; i < np; i++) sb.push_back({(i == ln - 1), 8'(sd + i)});
      len = 8'(ln);
      start_data = 8'(sd);
      gap = 4'(gp);
      start = 1'b1;
      m_ready = rdy[0];
      @(posedge clk);
      #1;
      for (int i = 0; i < n; i++) begin
         start = st[i];
         if (st[i]) begin
            len = 8'd5;
            start_data = 8'h50;
         end
         rst = rv[i];
         m_ready = rdy[i];
         @(negedge clk);
         cv[i] = m_valid;
         cl[i] = m_last;
         cd[i] = done;
         cb[i] = busy;
         cdat[i] = m_data;
         if (i < n - 1) begin
            @(posedge clk);
            #1;
         end
      end
      start = 1'b0;
      rst = 1'b0;
   endtask

   task pat(input string nm, input int n, input logic [15:0] ev, input logic [15:0] el,
            input logic [15:0] ed, input logic [15:0] eb, input int ehs, input int edn);
      logic [31:0] m;
      m = (32'd1 << n) - 1;
      chk({nm, "_valid"}, {16'd0, cv} & m, {16'd0, ev});
      chk({nm, "_last"}, {16'd0, cl} & m, {16'd0, el});
      chk({nm, "_done"}, {16'd0, cd} & m, {16'd0, ed});
      chk({nm, "_busy"}, {16'd0, cb} & m, {16'd0, eb});
      chk({nm, "_handshakes"}, 32'(hs_cnt - hs_base), 32'(ehs));
      chk({nm, "_done_pulses"}, 32'(done_cnt - done_base), 32'(edn));
      chk({nm, "_sb_drained"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_last", {31'd0, m_last}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_data", {24'd0, m_data}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      run(3, 'h01, 0, 3, 6, 16'hffff, 16'h0, 16'h0);
      chk("full_first_data", {24'd0, cdat[0]}, 32'h01);
      pat("full", 6, 16'b000111, 16'b000100, 16'b001000, 16'b001111, 3, 1);
      run(4, 'h10, 0, 4, 9, 16'hfff1, 16'h0, 16'h0);
      for (int i = 1; i < 4; i++) chk("bp_hold_data", {24'd0, cdat[i]}, 32'h11);
      pat("bp", 9, 16'b001111111, 16'b001000000, 16'b010000000, 16'b011111111, 4, 1);
      run(3, 'h20, 2, 3, 9, 16'hffff, 16'h0, 16'h0);
      chk("gap_mid_data", {24'd0, cdat[3]}, 32'h21);
      pat("gap", 9, 16'b001001001, 16'b001000000, 16'b010000000, 16'b011111111, 3, 1);
      run(3, 'hfe, 0, 3, 6, 16'hffff, 16'h0, 16'h0);
      pat("wrap", 6, 16'b000111, 16'b000100, 16'b001000, 16'b001111, 3, 1);
      run(0, 'h33, 0, 0, 3, 16'hffff, 16'h0, 16'h0);
      pat("zero", 3, 16'b000, 16'b000, 16'b001, 16'b001, 0, 1);
      run(2, 'h40, 0, 2, 6, 16'hffff, 16'b000110, 16'h0);
      pat("ignored_start", 6, 16'b000011, 16'b000010, 16'b000100, 16'b000111, 2, 1);
      run(6, 'h60, 0, 2, 6, 16'hffff, 16'h0, 16'b000100);
      pat("mid_reset", 6, 16'b000111, 16'b000000, 16'b000000, 16'b000111, 2, 0);
      run(2, 'h70, 0, 2, 6, 16'hffff, 16'h0, 16'h0);
      chk("after_rst_first_data", {24'd0, cdat[0]}, 32'h70);
      pat("after_rst", 6, 16'b000011, 16'b000010, 16'b000100, 16'b000111, 2, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
